retire_trace_unit: RTL and testbench

//  Transmit side of the WISC-F18 retirement trace. Samples the CPU's per-cycle commit

---
 rtl/wisc_trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 51 +++++
 rtl/retire_trace_unit.sv | 147 ++++++++++++++
 tb/tb_retire_trace_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_trace_pkg.sv
// Shared definitions for the WISC-F18 retirement trace: record kinds and field layout.
// Used by the transmit unit and the sink-side parser so both agree on bit positions.
// Record = {kind, inum, pc, reg, value, addr, 16'b0}; the low 16 bits are reserved zero.
package wisc_trace_pkg;

  localparam int KIND_W = 3;

  localparam logic [KIND_W-1:0] KIND_REG  = 3'd0;
  localparam logic [KIND_W-1:0] KIND_LD   = 3'd1;
  localparam logic [KIND_W-1:0] KIND_ST   = 3'd2;
  localparam logic [KIND_W-1:0] KIND_NOP  = 3'd3;
  localparam logic [KIND_W-1:0] KIND_HALT = 3'd4;

  localparam int PC_W   = 16;
  localparam int REG_W  = 4;
  localparam int VAL_W  = 16;
  localparam int ADDR_W = 16;

  // Bit offsets of the fields below inum; inum sits at TAIL_W, kind above it.
  localparam int ADDR_LSB  = 16;
  localparam int VALUE_LSB = 32;
  localparam int REG_LSB   = 48;
  localparam int PC_LSB    = 52;
  localparam int TAIL_W    = 68;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace records, DEPTH entries (power of 2).
// Latency: a pushed entry is readable at the head the cycle after the push.
// Backpressure: push while full is accepted only when a pop happens the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr];

  // Storage array; no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/retire_trace_unit.sv
// Classifies each retired instruction, tags it with a running INUM and queues it for the sink.
// Latency: a commit appears on rec_valid one cycle later when the queue was empty.
// Backpressure: rec_ready stalls the head; a commit into a full queue with no pop is dropped (overflow).
module retire_trace_unit
  import wisc_trace_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int INUM_W     = 16,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       commit_valid,
  input  logic [15:0]                c_pc,
  input  logic                       c_regwrite,
  input  logic [3:0]                 c_wreg,
  input  logic [15:0]                c_wdata,
  input  logic                       c_memread,
  input  logic                       c_memwrite,
  input  logic [15:0]                c_maddr,
  input  logic [15:0]                c_mdata,
  input  logic                       c_halt,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [KIND_W+INUM_W+TAIL_W-1:0] rec_data,
  output logic                       done,
  output logic                       overflow,
  output logic                       timeout
);

  localparam int REC_W = KIND_W + INUM_W + TAIL_W;
  localparam int CYC_W = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t              state;
  logic [INUM_W-1:0]   inum;
  logic [CYC_W-1:0]    cyc_cnt;
  logic                cyc_hit;

  logic [KIND_W-1:0]   kind;
  logic [REG_W-1:0]    rec_reg;
  logic [VAL_W-1:0]    rec_val;
  logic [ADDR_W-1:0]   rec_addr;
  logic [REC_W-1:0]    rec_in;
  logic [REC_W-1:0]    head;

  logic                push_req;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;

  assign push_req  = (state == ST_RUN) && commit_valid;
  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  assign drop      = push_req && fifo_full && !pop;
  assign cyc_hit   = (cyc_cnt == CYC_W'(MAX_CYCLES - 1));
  // Idle bus reads as zero rather than stale storage.
  assign rec_data  = rec_valid ? head : '0;

  // Classify the commit; first matching kind wins and unused fields stay zero.
  always_comb begin
    kind     = KIND_NOP;
    rec_reg  = '0;
    rec_val  = '0;
    rec_addr = '0;
    if (c_regwrite && c_memread) begin
      kind     = KIND_LD;
      rec_reg  = c_wreg;
      rec_val  = c_wdata;
      rec_addr = c_maddr;
    end else if (c_regwrite) begin
      kind    = KIND_REG;
      rec_reg = c_wreg;
      rec_val = c_wdata;
    end else if (c_halt) begin
      kind = KIND_HALT;
    end else if (c_memwrite) begin
      kind     = KIND_ST;
      rec_val  = c_mdata;
      rec_addr = c_maddr;
    end
  end

  // Pack the record using the shared field offsets.
  always_comb begin
    rec_in = '0;
    rec_in[REC_W-1 -: KIND_W]     = kind;
    rec_in[TAIL_W +: INUM_W]      = inum;
    rec_in[PC_LSB +: PC_W]        = c_pc;
    rec_in[REG_LSB +: REG_W]      = rec_reg;
    rec_in[VALUE_LSB +: VAL_W]    = rec_val;
    rec_in[ADDR_LSB +: ADDR_W]    = rec_addr;
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_req),
    .wr_dat (rec_in),
    .pop    (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // RUN/DRAIN/DONE control, INUM and cycle counters, sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      inum     <= '0;
      cyc_cnt  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      // INUM advances even for dropped records so the sink can see gaps.
      if (push_req) inum <= inum + 1'b1;
      if (drop)     overflow <= 1'b1;
      case (state)
        ST_RUN: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (push_req && (kind == KIND_HALT)) begin
            state <= ST_DRAIN;
          end else if (cyc_hit) begin
            timeout <= 1'b1;
            state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed bench for retire_trace_unit: table-driven classification vectors plus
// hand-written sequences for overflow, full-with-pop, halt drain, timeout and reset.
module tb_retire_trace_unit;

  localparam int DEPTH   = 8;
  localparam int INUM_W  = 16;
  localparam int MAX_CYC = 50;
  localparam int REC_W   = 3 + INUM_W + 68;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit_valid;
  logic [15:0]       c_pc;
  logic              c_regwrite;
  logic [3:0]        c_wreg;
  logic [15:0]       c_wdata;
  logic              c_memread;
  logic              c_memwrite;
  logic [15:0]       c_maddr;
  logic [15:0]       c_mdata;
  logic              c_halt;
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec_data;
  logic              done;
  logic              overflow;
  logic              timeout;

  always #5 clk = ~clk;

  retire_trace_unit #(
    .DEPTH      (DEPTH),
    .INUM_W     (INUM_W),
    .MAX_CYCLES (MAX_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .c_pc         (c_pc),
    .c_regwrite   (c_regwrite),
    .c_wreg       (c_wreg),
    .c_wdata      (c_wdata),
    .c_memread    (c_memread),
    .c_memwrite   (c_memwrite),
    .c_maddr      (c_maddr),
    .c_mdata      (c_mdata),
    .c_halt       (c_halt),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .done         (done),
    .overflow     (overflow),
    .timeout      (timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Record fields: kind[86:84] inum[83:68] pc[67:52] reg[51:48] value[47:32] addr[31:16] rsvd[15:0]
  function automatic logic [2:0]  f_kind(input logic [REC_W-1:0] r); return r[86:84]; endfunction
  function automatic logic [15:0] f_inum(input logic [REC_W-1:0] r); return r[83:68]; endfunction
  function automatic logic [15:0] f_pc  (input logic [REC_W-1:0] r); return r[67:52]; endfunction
  function automatic logic [3:0]  f_reg (input logic [REC_W-1:0] r); return r[51:48]; endfunction
  function automatic logic [15:0] f_val (input logic [REC_W-1:0] r); return r[47:32]; endfunction
  function automatic logic [15:0] f_addr(input logic [REC_W-1:0] r); return r[31:16]; endfunction
  function automatic logic [15:0] f_rsvd(input logic [REC_W-1:0] r); return r[15:0];  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    commit_valid = 1'b0; c_pc = '0; c_regwrite = 1'b0; c_wreg = '0; c_wdata = '0;
    c_memread = 1'b0; c_memwrite = 1'b0; c_maddr = '0; c_mdata = '0; c_halt = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rec_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive_reg(input logic [15:0] pc, input logic [3:0] wreg, input logic [15:0] wdata);
    clear_inputs();
    commit_valid = 1'b1;
    c_regwrite   = 1'b1;
    c_pc         = pc;
    c_wreg       = wreg;
    c_wdata      = wdata;
  endtask

  typedef struct packed {
    logic        rw, mr, mw, h;
    logic [15:0] pc;
    logic [3:0]  wreg;
    logic [15:0] wdata, maddr, mdata;
    logic [2:0]  ekind;
    logic [3:0]  ereg;
    logic [15:0] eval, eaddr;
  } vec_t;

  vec_t vt [7];

  logic [REC_W-1:0] prev;
  logic             held;
  int               got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rw    mr    mw    h     pc        wreg  wdata     maddr     mdata     kind  reg   value     addr
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 4'd3, 16'h00A5, 16'h0000, 16'h0000, 3'd0, 4'd3, 16'h00A5, 16'h0000};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 4'd1, 16'h1234, 16'h0040, 16'h0000, 3'd1, 4'd1, 16'h1234, 16'h0040};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0006, 4'd7, 16'h1111, 16'h0042, 16'hBEEF, 3'd2, 4'd0, 16'hBEEF, 16'h0042};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0008, 4'd5, 16'hFFFF, 16'h9999, 16'h7777, 3'd3, 4'd0, 16'h0000, 16'h0000};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h000A, 4'd2, 16'h0BAD, 16'h0100, 16'h2222, 3'd0, 4'd2, 16'h0BAD, 16'h0000};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h000C, 4'd6, 16'h3333, 16'h0200, 16'h4444, 3'd3, 4'd0, 16'h0000, 16'h0000};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h000E, 4'hF, 16'hCAFE, 16'h0300, 16'h5555, 3'd1, 4'hF, 16'hCAFE, 16'h0300};

    rst = 1'b1;
    do_reset();
    chk("reset_rec_valid", rec_valid, 0);
    chk("reset_done",      done,      0);
    chk("reset_overflow",  overflow,  0);
    chk("reset_timeout",   timeout,   0);
    chk("reset_rec_data",  rec_data,  0);

    // Classification table, one record per cycle with the sink always ready.
    rec_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      commit_valid = 1'b1;
      c_regwrite = vt[i].rw; c_memread = vt[i].mr; c_memwrite = vt[i].mw; c_halt = vt[i].h;
      c_pc = vt[i].pc; c_wreg = vt[i].wreg; c_wdata = vt[i].wdata;
      c_maddr = vt[i].maddr; c_mdata = vt[i].mdata;
      step();
      chk("tbl_valid", rec_valid, 1);
      chk("tbl_kind",  f_kind(rec_data), vt[i].ekind);
      chk("tbl_inum",  f_inum(rec_data), i);
      chk("tbl_pc",    f_pc(rec_data),   vt[i].pc);
      chk("tbl_reg",   f_reg(rec_data),  vt[i].ereg);
      chk("tbl_value", f_val(rec_data),  vt[i].eval);
      chk("tbl_addr",  f_addr(rec_data), vt[i].eaddr);
      chk("tbl_rsvd",  f_rsvd(rec_data), 0);
    end
    clear_inputs();
    step();
    chk("tbl_idle_no_rec", rec_valid, 0);

    // Nine commits into an eight-deep queue with the sink stalled.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_reg(16'h0100 + 16'(i), 4'(i), 16'(i));
      step();
    end
    clear_inputs();
    step();
    chk("ovf_flag",  overflow,  1);
    chk("ovf_valid", rec_valid, 1);
    rec_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("ovf_drain_valid", rec_valid, 1);
      chk("ovf_drain_inum",  f_inum(rec_data), j);
      chk("ovf_drain_value", f_val(rec_data),  j);
      step();
    end
    chk("ovf_empty", rec_valid, 0);
    drive_reg(16'h0200, 4'd0, 16'h0009);
    step();
    clear_inputs();
    chk("ovf_next_inum",   f_inum(rec_data), 9);
    chk("ovf_still_set",   overflow, 1);

    // Full queue: push coinciding with a pop is accepted.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_reg(16'h0300 + 16'(i), 4'(i), 16'(i));
      step();
    end
    drive_reg(16'h0308, 4'd8, 16'd8);
    rec_ready = 1'b1;
    step();
    clear_inputs();
    chk("full_pop_no_ovf", overflow, 0);
    for (int j = 1; j <= 8; j++) begin
      chk("full_pop_inum",  f_inum(rec_data), j);
      chk("full_pop_value", f_val(rec_data),  j);
      step();
    end
    chk("full_pop_empty", rec_valid, 0);
    chk("full_pop_ovf_end", overflow, 0);

    // Halt with three records queued; sink ready toggles; later commits must be ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_reg(16'h0010 + 16'(2*i), 4'(i+1), 16'h00A0 + 16'(i));
      step();
    end
    clear_inputs();
    commit_valid = 1'b1;
    c_halt = 1'b1;
    c_pc = 16'h001C;
    step();
    drive_reg(16'h0040, 4'd9, 16'h5555);
    got = 0;
    held = 1'b0;
    prev = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      rec_ready = (c % 2 == 1);
      if (held) chk("halt_stable", rec_data, prev);
      if (rec_valid && rec_ready) begin
        if (got < 4) begin
          chk("halt_kind", f_kind(rec_data), (got < 3) ? 3'd0 : 3'd4);
          chk("halt_inum", f_inum(rec_data), got);
          chk("halt_pc",   f_pc(rec_data),   (got < 3) ? 16'h0010 + 16'(2*got) : 16'h001C);
          if (got == 3) begin
            chk("halt_rec_reg",   f_reg(rec_data), 0);
            chk("halt_rec_value", f_val(rec_data), 0);
          end
        end
        got++;
      end
      held = rec_valid && !rec_ready;
      prev = rec_data;
      step();
    end
    chk("halt_count", got, 4);
    chk("halt_done",  done, 1);
    repeat (3) step();
    chk("halt_no_more_rec", rec_valid, 0);
    chk("halt_done_holds",  done, 1);
    chk("halt_no_timeout",  timeout, 0);
    clear_inputs();

    // Timeout with records stalled, then reset mid-drain.
    do_reset();
    drive_reg(16'h0060, 4'd1, 16'h0001);
    step();
    drive_reg(16'h0062, 4'd2, 16'h0002);
    step();
    clear_inputs();
    repeat (43) step();
    chk("to_not_yet", timeout, 0);
    for (int c = 0; c < 20 && !timeout; c++) step();
    chk("to_set",        timeout, 1);
    chk("to_not_done",   done, 0);
    chk("to_rec_held",   rec_valid, 1);
    drive_reg(16'h0070, 4'd3, 16'h0003);
    rec_ready = 1'b1;
    chk("to_drain_inum", f_inum(rec_data), 0);
    step();
    clear_inputs();
    rec_ready = 1'b0;
    chk("to_drain_inum2", f_inum(rec_data), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid",   rec_valid, 0);
    chk("rst_mid_timeout", timeout, 0);
    chk("rst_mid_done",    done, 0);
    chk("rst_mid_ovf",     overflow, 0);

    // Timeout with nothing queued runs through to done.
    rec_ready = 1'b1;
    for (int c = 0; c < 70 && !done; c++) step();
    chk("to_done",         done, 1);
    chk("to_done_timeout", timeout, 1);
    chk("to_done_valid",   rec_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
